// File: rtl/display_pkg.sv
// Shared constants, glyph table and digit-index type for the count display.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] GLYPH_U   = 7'b1000001;
  localparam logic [6:0] GLYPH_D   = 7'b0100001;

  // Active-low {g,f,e,d,c,b,a} glyphs for decimal digits 0..9
  localparam logic [6:0] DIGIT_GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Scan position; an[idx] is the lit anode
  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_BLANK = 2'd2,
    DIG_DIR   = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/count_display_seg_decode.sv
// Decimal digit to active-low seven-segment glyph; non-decimal inputs blank.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup, blank for 10..15
  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = DIGIT_GLYPH[digit];
  end

endmodule

// File: rtl/count_display.sv
// Four-digit multiplexed display of a 4-bit count (ones, tens, blank,
// direction glyph). Inputs are snapshotted once per frame.
module count_display
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] count,
  input  logic       dir,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  digit_idx_t    idx, idx_nxt;
  logic [3:0]    snap_cnt, cnt_nxt;
  logic          snap_dir, dir_nxt;
  logic          capture;
  logic [3:0]    ones;
  logic [6:0]    ones_seg;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  assign tick    = (presc == PRESC_MAX);
  assign idx_nxt = digit_idx_t'(idx + 2'd1);
  assign capture = tick && (idx == DIG_DIR);

  // Digit 0 is rendered on the capture edge itself, so decode from the
  // values about to be latched rather than the registered snapshot.
  assign cnt_nxt = capture ? count : snap_cnt;
  assign dir_nxt = capture ? dir   : snap_dir;
  assign ones    = (cnt_nxt >= 4'd10) ? (cnt_nxt - 4'd10) : cnt_nxt;

  seg_decode u_seg_decode (
    .digit (ones),
    .seg   (ones_seg)
  );

  // Select glyph and anode pattern for the digit being entered
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = ~(4'b0001 << idx_nxt);
    case (idx_nxt)
      DIG_ONES:  seg_nxt = ones_seg;
      DIG_TENS:  seg_nxt = (cnt_nxt >= 4'd10) ? DIGIT_GLYPH[1] : SEG_BLANK;
      DIG_BLANK: seg_nxt = SEG_BLANK;
      DIG_DIR:   seg_nxt = dir_nxt ? GLYPH_U : GLYPH_D;
      default:   seg_nxt = SEG_BLANK;
    endcase
  end

  // Prescaler wrapping at SCAN_DIV-1
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Scan index, frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx      <= DIG_DIR;
      snap_cnt <= '0;
      snap_dir <= 1'b0;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else if (tick) begin
      idx      <= idx_nxt;
      snap_cnt <= cnt_nxt;
      snap_dir <= dir_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with SCAN_DIV = 4.
module tb_count_display;

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] G_U = 7'b1000001;
  localparam logic [6:0] G_D = 7'b0100001;
  localparam logic [6:0] G1  = 7'b1111001;

  logic       clk;
  logic       nrst;
  logic [3:0] count;
  logic       dir;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  count_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .count (count),
    .dir   (dir),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       d;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s3;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Wait (sampling on negedges) until the given anode pattern is lit
  task automatic wait_an(input logic [3:0] target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_chk++;
      $display("FAIL %s: timeout waiting for an=%b, an=%b", name, target, an);
    end
  endtask

  // Release reset at a negedge and verify the dark interval is exactly 4 edges
  task automatic release_and_check_dark(input string name);
    @(negedge clk);
    nrst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e < 4) begin
        check($sformatf("%s_dark_an_e%0d", name, e), 32'(an), 32'(4'b1111));
        check($sformatf("%s_dark_seg_e%0d", name, e), 32'(seg), 32'(BLK));
      end else begin
        check($sformatf("%s_first_an", name), 32'(an), 32'(4'b1110));
      end
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{cnt: 4'd13, d: 1'b1, s0: 7'b0110000, s1: G1,  s3: G_U};
    vecs[1] = '{cnt: 4'd7,  d: 1'b0, s0: 7'b1111000, s1: BLK, s3: G_D};
    vecs[2] = '{cnt: 4'd0,  d: 1'b0, s0: 7'b1000000, s1: BLK, s3: G_D};
    vecs[3] = '{cnt: 4'd15, d: 1'b1, s0: 7'b0010010, s1: G1,  s3: G_U};
    vecs[4] = '{cnt: 4'd10, d: 1'b0, s0: 7'b1000000, s1: G1,  s3: G_D};
    vecs[5] = '{cnt: 4'd9,  d: 1'b1, s0: 7'b0010000, s1: BLK, s3: G_U};

    nrst  = 1'b0;
    count = 4'd0;
    dir   = 1'b1;
    #12;
    check("rst_an",  32'(an),  32'(4'b1111));
    check("rst_seg", 32'(seg), 32'(BLK));
    check("rst_dp",  32'(dp),  32'(1'b1));

    // Reset release: dark for 4 edges, then one digit every 4 edges
    release_and_check_dark("rel");
    check("rel_d0_seg", 32'(seg), 32'(7'b1000000));
    for (int k = 1; k <= 3; k++) begin
      repeat (4) @(posedge clk);
      #1;
      case (k)
        1: begin check("rel_e8_an", 32'(an), 32'(4'b1101));
                 check("rel_e8_seg", 32'(seg), 32'(BLK)); end
        2: begin check("rel_e12_an", 32'(an), 32'(4'b1011));
                 check("rel_e12_seg", 32'(seg), 32'(BLK)); end
        default: begin check("rel_e16_an", 32'(an), 32'(4'b0111));
                 check("rel_e16_seg", 32'(seg), 32'(G_U)); end
      endcase
    end

    // Table-driven frames: inputs change during digit 3, captured at wrap
    for (int v = 0; v < 6; v++) begin
      wait_an(4'b0111, $sformatf("vec%0d_sync", v));
      count = vecs[v].cnt;
      dir   = vecs[v].d;
      wait_an(4'b1110, $sformatf("vec%0d_d0", v));
      check($sformatf("vec%0d_d0_seg", v), 32'(seg), 32'(vecs[v].s0));
      check($sformatf("vec%0d_dp", v), 32'(dp), 32'(1'b1));
      wait_an(4'b1101, $sformatf("vec%0d_d1", v));
      check($sformatf("vec%0d_d1_seg", v), 32'(seg), 32'(vecs[v].s1));
      wait_an(4'b1011, $sformatf("vec%0d_d2", v));
      check($sformatf("vec%0d_d2_seg", v), 32'(seg), 32'(BLK));
      wait_an(4'b0111, $sformatf("vec%0d_d3", v));
      check($sformatf("vec%0d_d3_seg", v), 32'(seg), 32'(vecs[v].s3));
    end

    // Tearing: snapshot 9, then input moves to 10 mid-frame
    wait_an(4'b0111, "tear_sync");
    count = 4'd9;
    dir   = 1'b1;
    wait_an(4'b1110, "tear_d0");
    check("tear_d0_seg", 32'(seg), 32'(7'b0010000));
    count = 4'd10;
    wait_an(4'b1101, "tear_d1");
    check("tear_d1_seg", 32'(seg), 32'(BLK));
    wait_an(4'b1110, "tear_next_d0");
    check("tear_next_d0_seg", 32'(seg), 32'(7'b1000000));
    wait_an(4'b1101, "tear_next_d1");
    check("tear_next_d1_seg", 32'(seg), 32'(G1));

    // Counter wrap 15 -> 0 across a frame boundary
    wait_an(4'b0111, "wrap_sync");
    count = 4'd15;
    wait_an(4'b1110, "wrap_n_d0");
    check("wrap_n_d0_seg", 32'(seg), 32'(7'b0010010));
    wait_an(4'b1101, "wrap_n_d1");
    check("wrap_n_d1_seg", 32'(seg), 32'(G1));
    wait_an(4'b0111, "wrap_sync2");
    count = 4'd0;
    wait_an(4'b1110, "wrap_n1_d0");
    check("wrap_n1_d0_seg", 32'(seg), 32'(7'b1000000));
    wait_an(4'b1101, "wrap_n1_d1");
    check("wrap_n1_d1_seg", 32'(seg), 32'(BLK));

    // Asynchronous reset while digit 2 is lit, then dark interval again
    count = 4'd13;
    wait_an(4'b1011, "mid_sync");
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_an",  32'(an),  32'(4'b1111));
    check("mid_rst_seg", 32'(seg), 32'(BLK));
    repeat (2) @(posedge clk);
    release_and_check_dark("mid");
    check("mid_d0_seg", 32'(seg), 32'(7'b0110000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_display.md
Name: count_display

Overview:
Downstream display stage for the 4-bit up/down counter. It takes the counter's `count` value and `dir` bit and drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Digit 0: ones of `count` in decimal.
- Digit 1: tens of `count` in decimal.
- Digit 2: blank.
- Digit 3: direction glyph.
Inputs are snapshotted once per scan frame, so a displayed frame never tears.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit; legal range >= 1; prescaler width = max(1, clog2(SCAN_DIV)).

Ports:
clk  input  1  system clock, same domain as the counter
nrst  input  1  asynchronous active-low reset
count  input  4  counter value, unsigned 0..15
dir  input  1  counter direction; 1 = up, 0 = down
seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low
an  output  4  digit anodes, an[0] = rightmost, active low

Behaviour:
- Reset is asynchronous on nrst low. While in reset:
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Prescaler = 0, digit index idx = 3.
  - Snapshot registers snap_cnt = 0, snap_dir = 0.
- Reset asserted mid-scan forces the reset values immediately, with no clock edge needed.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick = (prescaler == SCAN_DIV-1).
  - If SCAN_DIV = 1, tick is asserted every cycle.
- On each tick edge:
  - idx advances modulo 4 (3 -> 0 wraps).
  - an, seg and dp are registered for the new idx on the same edge. Outputs are never driven combinationally.
- Snapshot:
  - On a tick edge where idx == 3, snap_cnt and snap_dir capture count and dir.
  - Digit 0 of that same edge is rendered from the newly captured values, not the stale ones.
  - count/dir changes between snapshots have no visible effect until the next frame.
- After nrst is released, outputs stay dark for exactly SCAN_DIV rising edges. On the SCAN_DIV-th edge: an = 4'b1110, showing digit 0 of the first snapshot.
- Digit content (an has exactly one bit low at a time after the first tick):
  - idx 0: ones = snap_cnt mod 10, decimal glyph.
  - idx 1: if snap_cnt >= 10, glyph '1' = 7'b1111001; else blank = 7'b1111111 (leading-zero suppression).
  - idx 2: blank.
  - idx 3: 'U' = 7'b1000001 when snap_dir = 1; 'd' = 7'b0100001 when snap_dir = 0.
- dp = 1 (off) at all times after reset.
- Glyphs 0..9, active low {g..a}: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Arithmetic and wrap:
  - Ones/tens use the 4-bit input only. Values 10..15 split as tens = 1, ones = value - 10.
  - A counter wrap 15 -> 0 or 0 -> 15 simply appears in the next frame as 0 or 15.
- No handshake: count and dir are level inputs, sampled synchronously. No X propagation is allowed from the snapshot registers, since they are reset.

Decomposition:
- Shared package `display_pkg`:
  - Constants SEG_BLANK, AN_OFF, GLYPH_U, GLYPH_D.
  - A 10-entry digit glyph table.
  - A 2-bit digit-index type.
- One natural combinational sub-module, `seg_decode`: 4-bit digit 0..9 -> 7-bit active-low glyph. Inputs above 9 map to SEG_BLANK.
- Prescaler, idx, snapshot and output registers live in count_display.

Test Plan:
All scenarios use SCAN_DIV = 4.
- Reset release with count = 0, dir = 1 -> an = 1111 and seg = 1111111 for 4 edges. At edge 4: an = 1110, seg = 1000000. At edge 8: an = 1101, seg = 1111111. At edge 12: an = 1011, blank. At edge 16: an = 0111, seg = 1000001.
- count = 13, dir = 1 held -> digit 0 seg = 0110000, digit 1 seg = 1111001, digit 2 blank, digit 3 seg = 1000001, dp = 1 throughout.
- count = 7, dir = 0 -> digit 0 seg = 1111000, digit 1 blank, digit 3 seg = 0100001.
- Tearing: snapshot taken at 9; count changes 9 -> 10 while idx = 1 is displayed -> digit 1 stays blank this frame. Next frame shows digit 0 = 1000000 and digit 1 = 1111001.
- Counter wrap: count steps 15 -> 0 across a frame boundary -> frame N shows '1','5' (1111001, 0010010); frame N+1 shows ones '0', tens blank.
- Reset mid-scan: assert nrst low asynchronously while an = 1011 -> an = 1111 and seg = 1111111 before the next clk edge. After release, the dark interval is again exactly 4 edges.
